result_tx_framer: RTL and testbench

//  Downstream of the neuron channel: takes one capture of N_CH 8-bit tanh results and

---
 rtl/result_tx_pkg.sv | 21 ++
 rtl/tx_byte_sel.sv | 40 ++++
 rtl/result_tx_framer.sv | 145 ++++++++++++++
 tb/tb_result_tx_framer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_tx_pkg.sv
// Shared definitions for the result transmit framer.
//   state_t        : framer FSM states (IDLE..DONE)
//   DEFAULT_HEADER : first byte of every frame unless overridden
//   OFS_*          : byte offsets inside a frame (header, count, first data byte)
package result_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    localparam int OFS_HDR  = 0;
    localparam int OFS_CNT  = 1;
    localparam int OFS_DATA = 2;

endpackage

// File: rtl/tx_byte_sel.sv
// Combinational byte selector for the result frame.
// Maps the current frame index to the byte that goes on the wire:
//   OFS_HDR -> HEADER, OFS_CNT -> N_CH, OFS_DATA+k -> channel k,
//   OFS_DATA+N_CH -> checksum (only reached when the checksum byte is enabled).
// Ports:
//   idx      in  IDXW     frame byte index
//   shadow   in  8*N_CH   captured results, channel k in bits [8k+7:8k]
//   checksum in  8        running XOR checksum
//   byte_out out 8        selected byte
module tx_byte_sel
    import result_tx_pkg::*;
#(
    parameter int         N_CH   = 4,
    parameter logic [7:0] HEADER = DEFAULT_HEADER,
    parameter int         IDXW   = 3
) (
    input  logic [IDXW-1:0]   idx,
    input  logic [8*N_CH-1:0] shadow,
    input  logic [7:0]        checksum,
    output logic [7:0]        byte_out
);

    always_comb begin
        byte_out = 8'h00;
        if (idx == IDXW'(OFS_HDR)) begin
            byte_out = HEADER;
        end else if (idx == IDXW'(OFS_CNT)) begin
            byte_out = 8'(N_CH);
        end else if (idx == IDXW'(OFS_DATA + N_CH)) begin
            byte_out = checksum;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (idx == IDXW'(OFS_DATA + k)) begin
                    byte_out = shadow[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/result_tx_framer.sv
// Result transmit framer: captures N_CH 8-bit results into a shadow register and
// sends them to the UART transmitter as one frame:
//   HEADER, N_CH, ch0 .. ch(N_CH-1) [, XOR checksum]
// Build option: define RESULT_TX_CHECKSUM_EN to append the checksum byte
// (XOR of every byte except the header).
// Handshakes:
//   capture : res_data is taken on a clock edge where res_valid && res_ready.
//             res_ready is high only in IDLE; res_valid at any other time is dropped.
//   uart    : tx_enable is a single-cycle request with tx_data held stable; the UART
//             acknowledges by pulling tx_ready low and finishes by raising it again.
// Ports:
//   clk        in   1        system clock, rising edge
//   reset      in   1        synchronous, active-low
//   res_data   in   8*N_CH   results, channel k in bits [8k+7:8k]
//   res_valid  in   1        res_data valid
//   res_ready  out  1        framer idle and able to capture
//   tx_data    out  8        byte to UART
//   tx_enable  out  1        one-cycle send request
//   tx_ready   in   1        UART idle
//   busy       out  1        frame in progress
//   frame_done out  1        one-cycle pulse after the last byte completes
//   state_dbg  out  3        current FSM state
module result_tx_framer
    import result_tx_pkg::*;
#(
    parameter int         N_CH   = 4,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8*N_CH-1:0] res_data,
    input  logic              res_valid,
    output logic              res_ready,
    output logic [7:0]        tx_data,
    output logic              tx_enable,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output state_t            state_dbg
);

    localparam int IDXW = $clog2(N_CH + 3);
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int LAST = N_CH + 2;
`else
    localparam int LAST = N_CH + 1;
`endif

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic [8*N_CH-1:0] shadow;
    logic [7:0]        checksum;
    logic [7:0]        cur_byte;

    tx_byte_sel #(
        .N_CH   (N_CH),
        .HEADER (HEADER),
        .IDXW   (IDXW)
    ) u_byte_sel (
        .idx      (idx),
        .shadow   (shadow),
        .checksum (checksum),
        .byte_out (cur_byte)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            shadow     <= '0;
            tx_data    <= 8'h00;
            tx_enable  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_enable  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        shadow <= res_data;
                        idx    <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tx_ready) begin
                        tx_data   <= cur_byte;
                        tx_enable <= 1'b1;
                        state     <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    // The UART pulling tx_ready low is the byte acknowledge.
                    if (!tx_ready) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_ready) begin
                        if (idx == IDXW'(LAST)) begin
                            // frame_done is high during DONE, where res_ready is low,
                            // so a capture in the same cycle is dropped.
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx   <= idx + IDXW'(1);
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0] csum_q;

    // Header and the checksum byte itself are not folded in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            csum_q <= 8'h00;
        end else if (state == IDLE && res_valid) begin
            csum_q <= 8'h00;
        end else if (state == ISSUE && tx_ready &&
                     idx != IDXW'(OFS_HDR) && idx != IDXW'(LAST)) begin
            csum_q <= csum_q ^ cur_byte;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

    assign res_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_result_tx_framer.sv
module tb_result_tx_framer;
    import result_tx_pkg::*;

`ifdef RESULT_TX_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b0;

    // ---------------- N_CH=4 instance ----------------
    logic [31:0] res_data  = '0;
    logic        res_valid = 1'b0;
    logic        res_ready, tx_enable, tx_ready, busy, frame_done;
    logic [7:0]  tx_data;
    state_t      state_dbg;

    result_tx_framer #(.N_CH(4), .HEADER(8'hA5)) dut (
        .clk(clk), .reset(reset), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .tx_data(tx_data), .tx_enable(tx_enable),
        .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
    );

    // ---------------- N_CH=1 instance ----------------
    logic [7:0] res_data1  = '0;
    logic       res_valid1 = 1'b0;
    logic       res_ready1, tx_enable1, tx_ready1, busy1, frame_done1;
    logic [7:0] tx_data1;
    state_t     state_dbg1;

    result_tx_framer #(.N_CH(1), .HEADER(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .res_data(res_data1), .res_valid(res_valid1),
        .res_ready(res_ready1), .tx_data(tx_data1), .tx_enable(tx_enable1),
        .tx_ready(tx_ready1), .busy(busy1), .frame_done(frame_done1), .state_dbg(state_dbg1)
    );

    // ---------------- UART models: ready drops 2 cycles after enable, low for 10 ----------------
    logic force_low = 1'b0;
    int   u_cnt  = 0;
    int   u1_cnt = 0;
    always @(posedge clk) begin
        if (tx_enable && u_cnt == 0) u_cnt <= 12;
        else if (u_cnt != 0)         u_cnt <= u_cnt - 1;
        if (tx_enable1 && u1_cnt == 0) u1_cnt <= 12;
        else if (u1_cnt != 0)          u1_cnt <= u1_cnt - 1;
    end
    assign tx_ready  = !(u_cnt >= 1 && u_cnt <= 10) && !force_low;
    assign tx_ready1 = !(u1_cnt >= 1 && u1_cnt <= 10);

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] got1_q[$];
    int en_cnt = 0, fd_cnt = 0, en1_cnt = 0, fd1_cnt = 0;
    int n_pass = 0, n_total = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (tx_enable)   begin got_q.push_back(tx_data);   en_cnt++;  end
            if (frame_done)  fd_cnt++;
            if (tx_enable1)  begin got1_q.push_back(tx_data1); en1_cnt++; end
            if (frame_done1) fd1_cnt++;
        end
    end

    // Reference frame: header, count, channels low-first, optional XOR of all but header.
    task automatic build_exp(input int n, input logic [31:0] d);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        x = 8'(n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(d[8*k +: 8]);
            x = x ^ d[8*k +: 8];
        end
        if (CSUM) exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        got_q.delete(); got1_q.delete();
        en_cnt = 0; fd_cnt = 0; en1_cnt = 0; fd1_cnt = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        n_total++; if (tx_enable !== 1'b0) $display("FAIL reset_tx_enable got %b exp 0", tx_enable); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else n_pass++;
        n_total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h exp 00", tx_data); else n_pass++;
        n_total++; if (res_ready !== 1'b1 || res_ready1 !== 1'b1) $display("FAIL reset_res_ready got %b/%b exp 1/1", res_ready, res_ready1); else n_pass++;
        n_total++; if (busy !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_busy got %b/%b exp 0/0", busy, busy1); else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_known_frame();
        bit done, ok;
        clear_sb();
        build_exp(4, 32'h40302010);
        res_data = 32'h40302010; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        n_total++; if (busy !== 1'b1 || res_ready !== 1'b0 || tx_enable !== 1'b0)
            $display("FAIL known_after_capture busy/rdy/en got %b/%b/%b exp 1/0/0", busy, res_ready, tx_enable); else n_pass++;
        done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin tick(); if (frame_done) done = 1; end
        n_total++; if (!done) $display("FAIL known_done_timeout got 0 exp 1"); else n_pass++;
        tick();
        ok = (got_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) begin
            $display("FAIL known_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); ok = 0; end
        n_total++; if (!ok) $display("FAIL known_frame got %0d bytes exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        n_total++; if (en_cnt != exp_q.size()) $display("FAIL known_enables got %0d exp %0d", en_cnt, exp_q.size()); else n_pass++;
        n_total++; if (fd_cnt != 1) $display("FAIL known_frame_done got %0d exp 1", fd_cnt); else n_pass++;
        n_total++; if (res_ready !== 1'b1 || busy !== 1'b0) $display("FAIL known_idle_after got %b/%b exp 1/0", res_ready, busy); else n_pass++;
    endtask

    task automatic test_random_frames();
        bit done, ok;
        logic [31:0] d;
        for (int f = 0; f < 4; f++) begin
            clear_sb();
            repeat ($urandom_range(0, 4)) tick();
            d = $urandom;
            build_exp(4, d);
            res_data = d; res_valid = 1'b1;
            tick();
            res_valid = 1'b0;
            done = 0;
            for (int c = 0; c < 2000 && !done; c++) begin tick(); if (frame_done) done = 1; end
            tick();
            ok = done && (got_q.size() == exp_q.size());
            for (int i = 0; ok && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) begin
                $display("FAIL rand%0d_byte%0d got %h exp %h", f, i, got_q[i], exp_q[i]); ok = 0; end
            n_total++; if (!ok) $display("FAIL rand%0d_frame got %0d bytes exp %0d (done=%0b)", f, got_q.size(), exp_q.size(), done); else n_pass++;
            n_total++; if (fd_cnt != 1) $display("FAIL rand%0d_frame_done got %0d exp 1", f, fd_cnt); else n_pass++;
        end
    endtask

    task automatic test_ignore_midframe();
        bit done, ok, rr_bad;
        clear_sb();
        build_exp(4, 32'hDEADBEEF);
        res_data = 32'hDEADBEEF; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        done = 0; rr_bad = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (c == 15 || c == 40) begin res_data = $urandom; res_valid = 1'b1; end
            else res_valid = 1'b0;
            tick();
            if (frame_done) done = 1;
            else if (res_ready !== 1'b0) rr_bad = 1;
        end
        res_valid = 1'b0;
        n_total++; if (rr_bad) $display("FAIL mid_res_ready got 1 exp 0"); else n_pass++;
        tick();
        ok = done && (got_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) begin
            $display("FAIL mid_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); ok = 0; end
        n_total++; if (!ok) $display("FAIL mid_frame got %0d bytes exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        repeat (5) tick();
        n_total++; if (busy !== 1'b0 || en_cnt != exp_q.size()) $display("FAIL mid_no_requeue busy %b en %0d exp 0/%0d", busy, en_cnt, exp_q.size()); else n_pass++;
    endtask

    task automatic test_tx_ready_low();
        bit done, ok, early;
        logic [31:0] d;
        clear_sb();
        d = $urandom;
        build_exp(4, d);
        force_low = 1'b1;
        res_data = d; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        early = 0;
        for (int c = 0; c < 20; c++) begin tick(); if (tx_enable) early = 1; end
        n_total++; if (early || en_cnt != 0) $display("FAIL hold_no_enable got %0d exp 0", en_cnt); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL hold_busy got %b exp 1", busy); else n_pass++;
        force_low = 1'b0;
        done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin tick(); if (frame_done) done = 1; end
        tick();
        ok = done && (got_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) begin
            $display("FAIL hold_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); ok = 0; end
        n_total++; if (!ok) $display("FAIL hold_frame got %0d bytes exp %0d", got_q.size(), exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit done, ok, seen3;
        int en_seen;
        logic [31:0] d;
        clear_sb();
        res_data = 32'h0BADF00D; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        en_seen = 0; seen3 = 0;
        for (int c = 0; c < 2000 && !seen3; c++) begin
            tick();
            if (tx_enable) en_seen++;
            if (en_seen == 3) seen3 = 1;
        end
        n_total++; if (!seen3) $display("FAIL rstmid_third_byte_timeout got %0d exp 3", en_seen); else n_pass++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_total++; if (tx_enable !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b1)
            $display("FAIL rstmid_after en/busy/rdy got %b/%b/%b exp 0/0/1", tx_enable, busy, res_ready); else n_pass++;
        clear_sb();
        d = $urandom;
        build_exp(4, d);
        res_data = d; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin tick(); if (frame_done) done = 1; end
        tick();
        ok = done && (got_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) begin
            $display("FAIL rstmid_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); ok = 0; end
        n_total++; if (!ok) $display("FAIL rstmid_frame got %0d bytes exp %0d", got_q.size(), exp_q.size()); else n_pass++;
    endtask

    task automatic test_n1_back_to_back();
        bit done, ok;
        clear_sb();
        build_exp(1, 32'h000000FF);
        res_data1 = 8'hFF; res_valid1 = 1'b1;
        tick();
        res_valid1 = 1'b0;
        done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin tick(); if (frame_done1) done = 1; end
        n_total++; if (!done) $display("FAIL n1_done_timeout got 0 exp 1"); else n_pass++;
        // Capture offered in the frame_done cycle must be dropped.
        res_data1 = 8'h33; res_valid1 = 1'b1;
        tick();
        res_valid1 = 1'b0;
        n_total++; if (busy1 !== 1'b0 || res_ready1 !== 1'b1) $display("FAIL n1_same_cycle_ignored busy/rdy got %b/%b exp 0/1", busy1, res_ready1); else n_pass++;
        ok = (got1_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (got1_q[i] !== exp_q[i]) begin
            $display("FAIL n1_byte%0d got %h exp %h", i, got1_q[i], exp_q[i]); ok = 0; end
        n_total++; if (!ok) $display("FAIL n1_frame got %0d bytes exp %0d", got1_q.size(), exp_q.size()); else n_pass++;
        // The next capture, one cycle later, is accepted.
        clear_sb();
        build_exp(1, 32'h0000005A);
        res_data1 = 8'h5A; res_valid1 = 1'b1;
        tick();
        res_valid1 = 1'b0;
        n_total++; if (busy1 !== 1'b1) $display("FAIL n1_next_accept got %b exp 1", busy1); else n_pass++;
        done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin tick(); if (frame_done1) done = 1; end
        tick();
        ok = done && (got1_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (got1_q[i] !== exp_q[i]) begin
            $display("FAIL n1b_byte%0d got %h exp %h", i, got1_q[i], exp_q[i]); ok = 0; end
        n_total++; if (!ok) $display("FAIL n1b_frame got %0d bytes exp %0d", got1_q.size(), exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_random_frames();
        test_ignore_midframe();
        test_tx_ready_low();
        test_reset_midframe();
        test_n1_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
